muldiv_seq: RTL and testbench

Multi-cycle RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse and holds busy so the core stalls. It runs a radix-2 iterative shift-add / restoring-divide loop under a small FSM, returns a registered 32-bit result with a one-cycle done pulse, and short-circuits the RISC-V divide-by-zero and signed-overflow cases.

---
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// Define MULDIV_FAST_MUL_EN to compute multiplies in PREP with one multiplier.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int DW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CLAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            dz_q, dz_d;

  logic            is_div, s1, s2, n1, n2;
  logic            bzero, ovf;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   madd, trial;
  logic [DW-1:0]   mstep, dsh, dstep, prod;
  logic [XLEN-1:0] dv, dres, mres;

  assign is_div = op_q[2];
  // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
  assign s1 = (op_q[2] & ~op_q[0]) | (~op_q[2] & (op_q[1] ^ op_q[0]));
  assign s2 = (op_q == 3'b001) | (op_q[2] & ~op_q[0]);
  assign n1 = s1 & a_q[XLEN-1];
  assign n2 = s2 & b_q[XLEN-1];
  assign abs1 = n1 ? -a_q : a_q;
  assign abs2 = n2 ? -b_q : b_q;
  assign bzero = (b_q == '0);
  assign ovf = op_q[2] & ~op_q[0] & (a_q == SMIN) & (b_q == '1);

  assign madd = {1'b0, acc_q[DW-1:XLEN]}
              + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mstep = {madd, acc_q[XLEN-1:1]};

  // The bit shifted out of the remainder joins the trial as its 33rd bit.
  assign dsh = {acc_q[DW-2:0], 1'b0};
  assign trial = acc_q[DW-1:XLEN-1] - {1'b0, opb_q};
  assign dstep = trial[XLEN] ? dsh
               : {trial[XLEN-1:0], dsh[XLEN-1:1], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign mres = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
              : prod[DW-1:XLEN];
  assign dv = op_q[1] ? acc_q[DW-1:XLEN] : acc_q[XLEN-1:0];
  assign dres = neg_q ? -dv : dv;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [DW-1:0] fa, fb, fprod;
  logic [XLEN-1:0]      fres;
  assign fa = {{XLEN{n1}}, a_q};
  assign fb = {{XLEN{n2}}, b_q};
  assign fprod = fa * fb;
  assign fres = (op_q[1:0] == 2'b00) ? fprod[XLEN-1:0]
              : fprod[DW-1:XLEN];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = funct3;
          a_d     = rs1_data;
          b_d     = rs2_data;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_d = (is_div && op_q[1]) ? n1 : (n1 ^ n2);
        cnt_d = '0;
        acc_d = is_div ? {{XLEN{1'b0}}, abs1}
              : {{XLEN{1'b0}}, abs2};
        opb_d = is_div ? abs2 : abs1;
        if (is_div && bzero) begin
          res_d   = op_q[1] ? a_q : '1;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else if (ovf) begin
          res_d   = op_q[1] ? '0 : SMIN;
          state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!is_div) begin
          res_d   = fres;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = is_div ? dstep : mstep;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLAST) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = is_div ? dres : mres;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      res_d   = res_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq.
// Expectations are queued at issue and popped at done.
module tb_muldiv_seq;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5;
  localparam logic [2:0] F_REM = 3'd6, F_REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, div_zero;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res;
  logic        last_dz;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
    string       name;
  } exp_t;
  exp_t sbq[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .funct3(funct3), .rs1_data(rs1), .rs2_data(rs2),
    .busy(busy), .done(done), .result(result),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] q, r;
    logic dz;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    q = '0;
    r = '0;
    p = '0;
    case (op)
      F_MUL:    p = ua * ub;
      F_MULH:   p = sa * sb;
      F_MULHSU: p = sa * ub;
      F_MULHU:  p = ua * ub;
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFFFFFF; r = a; dz = 1'b1;
        end else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          q = 32'h80000000; r = 32'd0;
        end else if (!op[0]) begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end else begin
          q = a / b;
          r = a % b;
        end
      end
    endcase
    if (!op[2]) return {1'b0, (op == F_MUL) ? p[31:0] : p[63:32]};
    return {dz, op[1] ? r : q};
  endfunction

  function automatic int lat_of(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    if (!op[2]) return MLAT;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er,
                       input logic edz, input int elat, input string nm);
    exp_t e;
    funct3 = op; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.res = er; e.dz = edz; e.lat = elat; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic collect(output int n, output logic [31:0] r,
                         output logic dz, output logic bok,
                         output logic to);
    n = 0; bok = 1'b1; to = 1'b0;
    while (!done) begin
      if (!busy) bok = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n > 100) begin to = 1'b1; break; end
    end
    if (!busy) bok = 1'b0;
    r = result; dz = div_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, div_zero} !== 35'd0) begin
      errors++;
      $display("FAIL reset: got %b/%b/%h/%b want 0/0/0/0",
               busy, done, result, div_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, done);
    end
    last_res = '0; last_dz = 1'b0;
  endtask

  task automatic run_table(input logic [2:0] op[], input logic [31:0] a[],
                           input logic [31:0] b[], input logic [31:0] er[],
                           input logic edz[], input int elat[]);
    int n; logic [31:0] r; logic dz, bok, to; exp_t e;
    for (int i = 0; i < op.size(); i++) begin
      issue(op[i], a[i], b[i], er[i], edz[i], elat[i],
            $sformatf("op%0d_%h_%h", op[i], a[i], b[i]));
      collect(n, r, dz, bok, to);
      e = sbq.pop_front();
      checks++;
      if (to !== 1'b0) begin
        errors++; $display("FAIL %s timeout: got no done want done", e.name);
      end
      checks++;
      if (r !== e.res) begin
        errors++; $display("FAIL %s result: got %h want %h", e.name, r, e.res);
      end
      checks++;
      if (dz !== e.dz) begin
        errors++; $display("FAIL %s div_zero: got %b want %b", e.name, dz, e.dz);
      end
      checks++;
      if (n !== e.lat) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", e.name, n, e.lat);
      end
      checks++;
      if (bok !== 1'b1) begin
        errors++; $display("FAIL %s busy: got low want high", e.name);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse: got busy=%b done=%b want 0/0", e.name, busy, done);
      end
      last_res = e.res; last_dz = e.dz;
    end
  endtask

  task automatic test_mul();
    run_table('{F_MUL, F_MULH, F_MULHU, F_MULHSU},
              '{32'd7, 32'h80000000, 32'h80000000, 32'h80000000},
              '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h80000000},
              '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hC0000000},
              '{1'b0, 1'b0, 1'b0, 1'b0},
              '{MLAT, MLAT, MLAT, MLAT});
  endtask

  task automatic test_div();
    run_table('{F_DIV, F_REM, F_DIVU},
              '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9},
              '{32'd2, 32'd2, 32'd2},
              '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC},
              '{1'b0, 1'b0, 1'b0},
              '{34, 34, 34});
  endtask

  task automatic test_special();
    run_table('{F_DIVU, F_REMU, F_DIV, F_REM},
              '{32'd5, 32'd5, 32'h80000000, 32'h80000000},
              '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
              '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0},
              '{1'b1, 1'b1, 1'b0, 1'b0},
              '{1, 1, 1, 1});
  endtask

  task automatic test_random();
    logic [2:0] op[12]; logic [31:0] a[12], b[12], er[12];
    logic edz[12]; int elat[12]; logic [32:0] m;
    for (int i = 0; i < 12; i++) begin
      op[i] = 3'($urandom_range(0, 7));
      a[i] = $urandom;
      b[i] = (i % 5 == 4) ? 32'd0 : ((i % 3 == 1) ? $urandom_range(1, 300) : $urandom);
      m = model(op[i], a[i], b[i]);
      er[i] = m[31:0]; edz[i] = m[32];
      elat[i] = lat_of(op[i], a[i], b[i]);
    end
    run_table(op, a, b, er, edz, elat);
  endtask

  task automatic test_ignore_start();
    int n; logic [31:0] r; logic dz, bok, to; exp_t e;
    issue(F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, MLAT, "ign");
    funct3 = F_DIVU; rs1 = 32'd99; rs2 = 32'd0; start = 1'b1;
    collect(n, r, dz, bok, to);
    start = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (r !== e.res || dz !== e.dz || n !== e.lat) begin
      errors++;
      $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d",
               e.name, r, dz, n, e.res, e.dz, e.lat);
    end
    @(posedge clk); #1;
    last_res = e.res; last_dz = e.dz;
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] r; logic dz, bok, to; exp_t e;
    issue(F_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, 34, "b2b_a");
    collect(n, r, dz, bok, to);
    e = sbq.pop_front();
    checks++;
    if (r !== e.res || n !== e.lat) begin
      errors++;
      $display("FAIL %s: got %h/%0d want %h/%0d", e.name, r, n, e.res, e.lat);
    end
    funct3 = F_REMU; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b done=%b want 0/0", busy, done);
    end
    issue(F_REMU, 32'd1000, 32'd7, 32'd6, 1'b0, 34, "b2b_b");
    collect(n, r, dz, bok, to);
    e = sbq.pop_front();
    checks++;
    if (r !== e.res || n !== e.lat || bok !== 1'b1) begin
      errors++;
      $display("FAIL %s: got %h/%0d/%b want %h/%0d/1",
               e.name, r, n, bok, e.res, e.lat);
    end
    @(posedge clk); #1;
    last_res = e.res; last_dz = e.dz;
  endtask

  task automatic test_flush();
    int n; logic [31:0] r; logic dz, bok, to; exp_t e;
    issue(F_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 34, "flushed");
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sbq.pop_back());
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: got busy=%b done=%b want 0/0", busy, done);
    end
    checks++;
    if (result !== last_res || div_zero !== last_dz) begin
      errors++;
      $display("FAIL flush_hold: got %h/%b want %h/%b",
               result, div_zero, last_res, last_dz);
    end
    issue(F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34, "after_flush");
    collect(n, r, dz, bok, to);
    e = sbq.pop_front();
    checks++;
    if (r !== e.res || dz !== e.dz || n !== e.lat) begin
      errors++;
      $display("FAIL %s: got %h/%b/%0d want %h/%b/%0d",
               e.name, r, dz, n, e.res, e.dz, e.lat);
    end
    @(posedge clk); #1;
    funct3 = F_DIVU; rs1 = 32'd5; rs2 = 32'd0;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_start: got busy=%b want 0", busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd14) begin
      errors++;
      $display("FAIL flush_start_done: got done=%b res=%h want 0/%h",
               done, result, 32'd14);
    end
  endtask

  task automatic test_rst_mid();
    issue(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, MLAT, "rst");
    void'(sbq.pop_back());
    issue(F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1, "rst_pre");
    void'(sbq.pop_back());
    repeat (3) @(posedge clk);
    #1;
    issue(F_DIV, 32'd1000, 32'd9, 32'd111, 1'b0, 34, "rst_mid");
    void'(sbq.pop_back());
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, result, div_zero} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid: got %b/%b/%h/%b want 0/0/0/0",
               busy, done, result, div_zero);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
